// File: rtl/qmult_pkg.sv
// Shared types and width/limit helpers for the sequential fixed-point multiplier family.
package qmult_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int W_MAX = 64;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [W_MAX-1:0] max_pos(input int n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

  function automatic logic [W_MAX-1:0] min_neg(input int n);
    return 64'd1 << (n - 1);
  endfunction

endpackage

// File: rtl/qmult_round_sat.sv
// Rounds a sign-magnitude Q-format product back to N bits, flags overflow and
// either saturates or wraps the signed result.
module qmult_round_sat
  import qmult_pkg::*;
#(
  parameter int Q        = 18,
  parameter int N        = 32,
  parameter int SAT_EN   = 1,
  parameter int ROUND_EN = 1
) (
  input  logic [2*N-Q:0]      prod_hi,
  input  logic                neg,
  output logic signed [N-1:0] result,
  output logic                ovr
);

  localparam int MW = 2*N - Q;
  localparam logic [N-1:0] MAX_POS = N'(max_pos(N));
  localparam logic [N-1:0] MIN_NEG = N'(min_neg(N));

  logic [MW-1:0] mag;
  logic [MW-1:0] lim;

  // prod_hi[0] is bit Q-1 of the full product, the half-LSB of the result.
  function automatic logic [MW-1:0] round_mag(input logic [2*N-Q:0] p);
    logic [MW-1:0] rb;
    rb = '0;
    if (ROUND_EN != 0) rb[0] = p[0];
    return p[MW:1] + rb;
  endfunction

  function automatic logic [N-1:0] sat_wrap(input logic [MW-1:0] m, input logic sgn,
                                            input logic over);
    logic [MW-1:0] s;
    s = sgn ? -m : m;
    if (over && (SAT_EN != 0)) return sgn ? MIN_NEG : MAX_POS;
    return s[N-1:0];
  endfunction

  always_comb begin
    mag    = round_mag(prod_hi);
    lim    = neg ? MW'(MIN_NEG) : MW'(MAX_POS);
    ovr    = (mag > lim);
    result = sat_wrap(mag, neg, ovr);
  end

endmodule

// File: rtl/qmult_seq.sv
// Bit-serial signed Q-format multiplier with valid/ready handshakes on both sides;
// one product takes N shift-add cycles followed by a single DONE cycle.
module qmult_seq
  import qmult_pkg::*;
#(
  parameter int Q        = 18,
  parameter int N        = 32,
  parameter int SAT_EN   = 1,
  parameter int ROUND_EN = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [N-1:0] result,
  output logic                ovr
);

  localparam int CNT_W = cnt_w(N);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*N-1:0]     mcand_q;
  logic [2*N-1:0]     acc_q;
  logic [2*N-1:0]     acc_nxt;
  logic [N-1:0]       mplier_q;
  logic               neg_q;
  logic               accept;
  logic               last;
  logic signed [N-1:0] rs_result;
  logic               rs_ovr;

  // |-2^(N-1)| wraps to 2^(N-1), which is exactly right as an unsigned N-bit value.
  function automatic logic [N-1:0] mag_of(input logic signed [N-1:0] x);
    logic signed [N-1:0] nx;
    nx = -x;
    return x[N-1] ? nx : x;
  endfunction

  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;
  assign last      = (cnt_q == CNT_W'(N - 1));
  assign acc_nxt   = acc_q + (mplier_q[0] ? mcand_q : '0);

  qmult_round_sat #(
    .Q        (Q),
    .N        (N),
    .SAT_EN   (SAT_EN),
    .ROUND_EN (ROUND_EN)
  ) u_round_sat (
    .prod_hi (acc_nxt[2*N-1:Q-1]),
    .neg     (neg_q),
    .result  (rs_result),
    .ovr     (rs_ovr)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      result   <= '0;
      ovr      <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            neg_q    <= a[N-1] ^ b[N-1];
            mcand_q  <= {{N{1'b0}}, mag_of(a)};
            mplier_q <= mag_of(b);
            acc_q    <= '0;
            cnt_q    <= '0;
          end
        end
        CALC: begin
          acc_q    <= acc_nxt;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          // Final iteration: the round/sat stage already sees the complete product.
          if (last) begin
            result <= rs_result;
            ovr    <= rs_ovr;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
